// File: rtl/iq_ctrl_pkg.sv
// Shared definitions for the IQ demodulator sequencer.
//   state_t : controller state encoding (IDLE=0, ARM=1, RUN=2, DRAIN=3)
//   IQ_DW   : default sample width
//   pair_t  : one I/Q pair as carried through the pair FIFO
package iq_ctrl_pkg;

    localparam int IQ_DW = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [IQ_DW-1:0] i;
        logic [IQ_DW-1:0] q;
    } pair_t;

endpackage

// File: rtl/iq_demod_ctrl_if.sv
// Pair stream from the sequencer to the demodulation core.
//   demod_i / demod_q : head pair (driven by master)
//   demod_valid       : head pair valid (driven by master)
//   demod_ready       : core accepts the head pair (driven by slave)
interface iq_demod_ctrl_if
    import iq_ctrl_pkg::*;
#(
    parameter int DW = IQ_DW
) ();

    logic [DW-1:0] demod_i;
    logic [DW-1:0] demod_q;
    logic          demod_valid;
    logic          demod_ready;

    modport master (
        output demod_i,
        output demod_q,
        output demod_valid,
        input  demod_ready
    );

    modport slave (
        input  demod_i,
        input  demod_q,
        input  demod_valid,
        output demod_ready
    );

endinterface

// File: rtl/iq_pair_fifo.sv
// First-word-fall-through FIFO with a registered head.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle (caller guarantees room, see below)
//   push_data  : W-bit entry
//   pop        : consume the head this cycle (caller only pops when head_valid)
//   full/empty : storage state from the pointers
//   head_data  : registered copy of the oldest entry, 0 when nothing is held
//   head_valid : head_data holds a real entry
// The head register is a registered read of the storage array; the entry
// stays in the array (and counts toward full) until it is popped. A push
// while full is legal only together with a pop, because the popped slot is
// the one being written.
module iq_pair_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data,
    output logic         head_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] head_q;
    logic         head_valid_q, head_valid_d;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
        // Compare against the pre-edge write pointer: an entry written on
        // this edge becomes visible one edge later.
        head_valid_d = (rd_ptr_d != wr_ptr_q);
    end

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_valid_q <= head_valid_d;
            if (head_valid_d) begin
                head_q <= mem[rd_ptr_d[AW-1:0]];
            end else begin
                head_q <= '0;
            end
        end
    end

    assign head_data  = head_q;
    assign head_valid = head_valid_q;

endmodule

// File: rtl/iq_demod_ctrl.sv
// Sequencer between an interleaved I/Q receive bus and a demodulation core.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start/stop  : one-cycle frame start / abort commands
//   iq_in       : interleaved sample word, iq_sel=1 -> I, iq_sel=0 -> Q
//   dmd         : pair stream to the demod core (valid/ready)
//   busy        : controller not in IDLE
//   frame_done  : one-cycle pulse when a frame has fully drained
//   pair_cnt    : pairs accepted into the FIFO this frame
//   overflow    : sticky, a pair was dropped on a full FIFO
//   sync_err    : sticky, a Q word arrived with no pending I
module iq_demod_ctrl
    import iq_ctrl_pkg::*;
#(
    parameter int DW         = IQ_DW,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 256,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DW-1:0]    iq_in,
    input  logic             iq_sel,
    iq_demod_ctrl_if.master  dmd,
    output logic             busy,
    output logic             frame_done,
    output logic [CW-1:0]    pair_cnt,
    output logic             overflow,
    output logic             sync_err
);

    state_t        state_q, state_d;
    logic [DW-1:0] i_hold_q, i_hold_d;
    logic          i_pend_q, i_pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          serr_q, serr_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;

    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          head_valid;
    logic [2*DW-1:0] head_data;

    assign pop = head_valid && dmd.demod_ready;

    always_comb begin
        state_d      = state_q;
        i_hold_d     = i_hold_q;
        i_pend_d     = i_pend_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        serr_d       = serr_q;
        frame_done_d = 1'b0;
        push_req     = 1'b0;
        push_ok      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ARM;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    serr_d   = 1'b0;
                    i_pend_d = 1'b0;
                end
            end

            ST_ARM: begin
                // Stray Q words before the first I are alignment slack,
                // not errors.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (iq_sel) begin
                    i_hold_d = iq_in;
                    i_pend_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (iq_sel) begin
                    i_hold_d = iq_in;
                    i_pend_d = 1'b1;
                end else if (i_pend_q) begin
                    push_req = 1'b1;
                    i_pend_d = 1'b0;
                end else begin
                    serr_d = 1'b1;
                end

                // A pop on the same edge frees the slot being written.
                push_ok = push_req && (!fifo_full || pop);
                if (push_ok) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (push_req) begin
                    ovf_d = 1'b1;
                end

                // The pair completing on a stop cycle is still taken above.
                if (stop || (cnt_d == CW'(FRAME_LEN))) begin
                    state_d  = ST_DRAIN;
                    i_pend_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (fifo_empty && !head_valid) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            i_hold_q     <= '0;
            i_pend_q     <= 1'b0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            serr_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_hold_q     <= i_hold_d;
            i_pend_q     <= i_pend_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            serr_q       <= serr_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    iq_pair_fifo #(
        .W     (2 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_ok),
        .push_data  ({i_hold_q, iq_in}),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

    assign dmd.demod_i     = head_data[2*DW-1:DW];
    assign dmd.demod_q     = head_data[DW-1:0];
    assign dmd.demod_valid = head_valid;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign pair_cnt   = cnt_q;
    assign overflow   = ovf_q;
    assign sync_err   = serr_q;

endmodule
